// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared pipeline types for the multicore datapath.
//   word_t        - 32-bit datapath word
//   regbits_t     - register-select field
//   exmem_state_t - EX/MEM stage occupancy
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;
    typedef enum logic [1:0] {EMPTY, READY, MEMWAIT, HALTED} exmem_state_t;
endpackage

// File: rtl/exmem_stage_link_reg.sv
// link_reg: LL/SC link register with coherence snoop and SC success check.
//   CLK, nRST            - clock, async active-low reset (link invalid)
//   set, set_addr        - LL completing: link to set_addr
//   clr                  - SC completing: consume the link
//   ccinv, ccsnoopaddr   - coherence invalidate of a matching link
//   chk_addr, sc_ok      - SC being captured at chk_addr would succeed
module link_reg #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              set,
    input  logic [WORD_W-1:0] set_addr,
    input  logic              clr,
    input  logic              ccinv,
    input  logic [WORD_W-1:0] ccsnoopaddr,
    input  logic [WORD_W-1:0] chk_addr,
    output logic              sc_ok
);
    logic [WORD_W-1:0] addr_q, addr_d;
    logic              vld_q, vld_d;

    // The SC check sees the link as it stands after this edge: a completing
    // LL/SC is applied first and a snoop invalidate is applied last, so an
    // invalidate always beats an SC captured in the same cycle.
    always_comb begin
        addr_d = set ? set_addr : addr_q;
        vld_d  = (set || (vld_q && !clr)) && !(ccinv && ccsnoopaddr == addr_d);
        sc_ok  = vld_d && addr_d == chk_addr;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            vld_q  <= vld_d;
        end
    end
endmodule

// File: rtl/exmem_stage.sv
// exmem_stage: EX/MEM pipeline register owning the dcache request/response handshake.
//   CLK, nRST                 - clock, async active-low reset
//   valid_i, flush            - execute holds an instruction / capture a bubble instead
//   aluout_i .. npc_i         - executed instruction fields and controls
//   dhit, dmemload            - dcache completion and read data
//   ccinv, ccsnoopaddr        - coherence invalidate (LL/SC only)
//   dmemREN/WEN/addr/store    - dcache request, held while MEMWAIT
//   stall_o                   - hold upstream stages
//   valid_o .. halt_o         - completed instruction toward MEM/WB
// Build option: define LLSC_EN for load-linked/store-conditional with a link register.
module exmem_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              valid_i,
    input  logic              flush,
    input  logic [WORD_W-1:0] aluout_i,
    input  logic [WORD_W-1:0] rdat2_i,
    input  logic [REG_W-1:0]  wsel_i,
    input  logic              RegW_i,
    input  logic              DRen_i,
    input  logic              DWen_i,
    input  logic              ll_i,
    input  logic              sc_i,
    input  logic              halt_i,
    input  logic [WORD_W-1:0] npc_i,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    input  logic              ccinv,
    input  logic [WORD_W-1:0] ccsnoopaddr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              stall_o,
    output logic              valid_o,
    output logic [WORD_W-1:0] aluout_o,
    output logic [WORD_W-1:0] dload_o,
    output logic [REG_W-1:0]  wsel_o,
    output logic              RegW_o,
    output logic [WORD_W-1:0] npc_o,
    output logic              halt_o
);
    typedef struct packed {
        logic [WORD_W-1:0] aluout;
        logic [WORD_W-1:0] rdat2;
        logic [WORD_W-1:0] npc;
        logic [REG_W-1:0]  wsel;
        logic              RegW;
        logic              DRen;
        logic              DWen;
        logic              ll;
        logic              sc;
    } fields_t;

    exmem_state_t state_q, state_d;
    fields_t      f_q, f_d;
    logic         mem, done, take, sc_ok;

    assign mem  = state_q == MEMWAIT;
    assign done = mem && dhit;
    assign take = valid_i && !flush;

`ifdef LLSC_EN
    link_reg #(.WORD_W(WORD_W)) u_link (
        .CLK        (CLK),
        .nRST       (nRST),
        .set        (done && f_q.ll && f_q.DRen),
        .set_addr   (f_q.aluout),
        .clr        (done && f_q.sc),
        .ccinv      (ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .chk_addr   (aluout_i),
        .sc_ok      (sc_ok)
    );
`else
    logic unused_llsc;
    assign sc_ok       = 1'b1;
    assign unused_llsc = &{1'b0, f_q.ll, ccinv, ccsnoopaddr};
`endif

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        if (!stall_o) begin
            f_d     = take ? {aluout_i, rdat2_i, npc_i, wsel_i, RegW_i, DRen_i, DWen_i, ll_i, sc_i} : '0;
            state_d = !take ? EMPTY : halt_i ? HALTED : (sc_i && !sc_ok) ? READY :
                      (DRen_i || DWen_i) ? MEMWAIT : READY;
            // A failed SC never touches memory; it completes as a register write of 0.
            if (take && !halt_i && sc_i && !sc_ok) begin
                f_d.aluout = '0;
                f_d.RegW   = 1'b1;
                f_d.DRen   = 1'b0;
                f_d.DWen   = 1'b0;
                f_d.sc     = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= EMPTY;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
        end
    end

    assign stall_o   = (mem && !dhit) || state_q == HALTED;
    assign dmemWEN   = mem && f_q.DWen;
    assign dmemREN   = mem && f_q.DRen && !f_q.DWen;
    assign dmemaddr  = mem ? f_q.aluout : '0;
    assign dmemstore = mem ? f_q.rdat2 : '0;
    assign valid_o   = state_q == READY || done;
    assign aluout_o  = f_q.sc ? WORD_W'(1) : f_q.aluout;
    assign dload_o   = (done && f_q.DRen) ? dmemload : '0;
    assign wsel_o    = f_q.wsel;
    assign RegW_o    = f_q.RegW && valid_o;
    assign npc_o     = f_q.npc;
    assign halt_o    = state_q == HALTED;
endmodule

// File: tb/tb_exmem_stage.sv
// tb_exmem_stage: vector table, directed corner sequences and randomized model check for exmem_stage.
module tb_exmem_stage;
`ifdef LLSC_EN
    localparam bit LLSC = 1'b1;
`else
    localparam bit LLSC = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST;
    logic        valid_i, flush, RegW_i, DRen_i, DWen_i, ll_i, sc_i, halt_i, dhit, ccinv;
    logic [31:0] aluout_i, rdat2_i, npc_i, dmemload, ccsnoopaddr;
    logic [4:0]  wsel_i;
    logic        dmemREN, dmemWEN, stall_o, valid_o, RegW_o, halt_o;
    logic [31:0] dmemaddr, dmemstore, aluout_o, dload_o, npc_o;
    logic [4:0]  wsel_o;

    int n_cmp, n_err;

    exmem_stage dut (
        .CLK(CLK), .nRST(nRST), .valid_i(valid_i), .flush(flush),
        .aluout_i(aluout_i), .rdat2_i(rdat2_i), .wsel_i(wsel_i), .RegW_i(RegW_i),
        .DRen_i(DRen_i), .DWen_i(DWen_i), .ll_i(ll_i), .sc_i(sc_i), .halt_i(halt_i),
        .npc_i(npc_i), .dhit(dhit), .dmemload(dmemload), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .stall_o(stall_o),
        .valid_o(valid_o), .aluout_o(aluout_o), .dload_o(dload_o), .wsel_o(wsel_o),
        .RegW_o(RegW_o), .npc_o(npc_o), .halt_o(halt_o)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic v, fl, rd, wr, rw, ll, sc, hl, input logic [4:0] ws,
                         input logic [31:0] alu, d2, input logic dh, input logic [31:0] dml);
        valid_i = v; flush = fl; DRen_i = rd; DWen_i = wr; RegW_i = rw; ll_i = ll;
        sc_i = sc; halt_i = hl; wsel_i = ws; aluout_i = alu; rdat2_i = d2;
        npc_i = alu + 32'd4; dhit = dh; dmemload = dml;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ccinv = 0; ccsnoopaddr = 0;
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    typedef struct {
        logic v, fl, rd, wr, rw;
        logic [4:0]  ws;
        logic [31:0] alu, d2;
        logic        dh;
        logic [31:0] dml;
        logic        e_st, e_vo, e_ren, e_wen;
        logic [31:0] e_addr, e_sto, e_dl, e_alu;
        logic [4:0]  e_ws;
        logic        e_rw;
    } vec_t;
    vec_t tbl[14];

    // LL/SC sequence: LL 0x300, optional snoop invalidate, then SC 0x300.
    task automatic sc_seq(input bit inv);
        bit fail;
        fail = LLSC && inv;
        drive(1, 0, 1, 0, 1, 1, 0, 0, 4, 32'h300, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAB);
        @(negedge CLK);
        chk($sformatf("ll%0d valid", inv), valid_o, 1);
        chk($sformatf("ll%0d dload", inv), dload_o, 32'hAB);
        tick();
        idle(); ccinv = inv; ccsnoopaddr = 32'h300; tick();
        ccinv = 0;
        drive(1, 0, 0, 1, 1, 0, 1, 0, 4, 32'h300, 32'h77, 0, 0); tick();
        idle();
        @(negedge CLK);
        chk($sformatf("sc%0d wen", inv), dmemWEN, !fail);
        chk($sformatf("sc%0d addr", inv), dmemaddr, fail ? 0 : 32'h300);
        chk($sformatf("sc%0d valid pre", inv), valid_o, fail);
        dhit = 1; #1;
        chk($sformatf("sc%0d valid", inv), valid_o, 1);
        chk($sformatf("sc%0d result", inv), aluout_o, fail ? 0 : 1);
        chk($sformatf("sc%0d regw", inv), RegW_o, 1);
        tick(); idle();
    endtask

    // Reference model: what instruction the stage holds and whether it is
    // waiting on memory, plus the link as an address/valid pair.
    typedef struct {
        bit [31:0] addr, res, st, npc;
        bit [4:0]  ws;
        bit        rw, rd, wr, ll, sc;
    } rec_t;
    rec_t      r;
    bit        m_busy, m_ready, m_halted, link_v;
    bit [31:0] link_a;

    task automatic model_reset();
        r = '{default: 0};
        m_busy = 0; m_ready = 0; m_halted = 0; link_v = 0; link_a = 0;
    endtask

    task automatic model_check(input int c);
        bit ex_stall, ex_valid;
        ex_stall = (m_busy && !dhit) || m_halted;
        ex_valid = m_ready || (m_busy && dhit);
        chk($sformatf("c%0d stall", c), stall_o, ex_stall);
        chk($sformatf("c%0d valid", c), valid_o, ex_valid);
        chk($sformatf("c%0d ren", c), dmemREN, m_busy && r.rd && !r.wr);
        chk($sformatf("c%0d wen", c), dmemWEN, m_busy && r.wr);
        chk($sformatf("c%0d addr", c), dmemaddr, m_busy ? r.addr : 0);
        chk($sformatf("c%0d store", c), dmemstore, m_busy ? r.st : 0);
        chk($sformatf("c%0d dload", c), dload_o, (m_busy && dhit && r.rd) ? dmemload : 0);
        chk($sformatf("c%0d aluout", c), aluout_o, r.res);
        chk($sformatf("c%0d wsel", c), wsel_o, r.ws);
        chk($sformatf("c%0d regw", c), RegW_o, r.rw && ex_valid);
        chk($sformatf("c%0d npc", c), npc_o, r.npc);
        chk($sformatf("c%0d halt", c), halt_o, m_halted);
    endtask

    task automatic model_edge();
        bit stall, done, ok;
        stall = (m_busy && !dhit) || m_halted;
        done  = m_busy && dhit;
        if (LLSC) begin
            if (done && r.ll) begin link_a = r.addr; link_v = 1; end
            if (done && r.sc) link_v = 0;
            if (ccinv && ccsnoopaddr == link_a) link_v = 0;
        end
        if (stall) return;
        m_busy = 0; m_ready = 0;
        if (!valid_i || flush) begin
            r = '{default: 0};
            return;
        end
        r = '{addr: aluout_i, res: aluout_i, st: rdat2_i, npc: npc_i, ws: wsel_i,
              rw: RegW_i, rd: DRen_i, wr: DWen_i, ll: LLSC && ll_i, sc: sc_i};
        ok = !LLSC || (link_v && link_a == aluout_i);
        if (halt_i) m_halted = 1;
        else if (sc_i && !ok) begin
            r.res = 0; r.rw = 1; r.rd = 0; r.wr = 0; r.sc = 0; m_ready = 1;
        end else if (DRen_i || DWen_i) begin
            m_busy = 1;
            if (sc_i) r.res = 1;
        end else m_ready = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_err = 0;
        tbl[0]  = '{1,0,1,0,1,3,'h100,0,0,0,          0,0,0,0,0,0,0,0,0,0};
        tbl[1]  = '{0,0,0,0,0,0,0,0,0,0,              1,0,1,0,'h100,0,0,'h100,3,0};
        tbl[2]  = tbl[1];
        tbl[3]  = tbl[1];
        tbl[4]  = '{1,0,0,0,1,5,7,0,1,'hDEADBEEF,     0,1,1,0,'h100,0,'hDEADBEEF,'h100,3,1};
        tbl[5]  = '{0,0,0,0,0,0,0,0,0,0,              0,1,0,0,0,0,0,7,5,1};
        tbl[6]  = '{1,0,0,1,0,0,'h200,'h11,0,0,       0,0,0,0,0,0,0,0,0,0};
        tbl[7]  = '{1,0,0,1,0,0,'h204,'h22,1,0,       0,1,0,1,'h200,'h11,0,'h200,0,0};
        tbl[8]  = '{0,0,0,0,0,0,0,0,1,0,              0,1,0,1,'h204,'h22,0,'h204,0,0};
        tbl[9]  = '{0,0,0,0,0,0,0,0,1,'h12345678,     0,0,0,0,0,0,0,0,0,0};
        tbl[10] = '{1,0,1,0,1,2,'h40,0,0,0,           0,0,0,0,0,0,0,0,0,0};
        tbl[11] = '{1,1,0,0,1,9,'h99,0,0,0,           1,0,1,0,'h40,0,0,'h40,2,0};
        tbl[12] = '{1,1,0,0,1,9,'h99,0,1,'h55,        0,1,1,0,'h40,0,'h55,'h40,2,1};
        tbl[13] = '{0,0,0,0,0,0,0,0,0,0,              0,0,0,0,0,0,0,0,0,0};

        nRST = 0; idle();
        repeat (2) tick();
        @(negedge CLK);
        chk("rst stall", stall_o, 0);
        chk("rst valid", valid_o, 0);
        chk("rst halt", halt_o, 0);
        chk("rst ren", dmemREN, 0);
        chk("rst wen", dmemWEN, 0);
        chk("rst aluout", aluout_o, 0);
        chk("rst npc", npc_o, 0);
        tick(); nRST = 1;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].fl, tbl[i].rd, tbl[i].wr, tbl[i].rw, 0, 0, 0,
                  tbl[i].ws, tbl[i].alu, tbl[i].d2, tbl[i].dh, tbl[i].dml);
            @(negedge CLK);
            chk($sformatf("row%0d stall", i), stall_o, tbl[i].e_st);
            chk($sformatf("row%0d valid", i), valid_o, tbl[i].e_vo);
            chk($sformatf("row%0d ren", i), dmemREN, tbl[i].e_ren);
            chk($sformatf("row%0d wen", i), dmemWEN, tbl[i].e_wen);
            chk($sformatf("row%0d addr", i), dmemaddr, tbl[i].e_addr);
            chk($sformatf("row%0d store", i), dmemstore, tbl[i].e_sto);
            chk($sformatf("row%0d dload", i), dload_o, tbl[i].e_dl);
            chk($sformatf("row%0d aluout", i), aluout_o, tbl[i].e_alu);
            chk($sformatf("row%0d wsel", i), wsel_o, tbl[i].e_ws);
            chk($sformatf("row%0d regw", i), RegW_o, tbl[i].e_rw);
            tick();
        end

        // Halt is sticky, blocks captures, and only reset clears it.
        drive(1, 0, 0, 0, 1, 0, 0, 1, 7, 32'h55, 0, 0, 0);
        @(negedge CLK);
        chk("halt pre", halt_o, 0);
        tick();
        drive(1, 0, 0, 0, 1, 0, 0, 0, 8, 32'h9, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk($sformatf("halt%0d halt", k), halt_o, 1);
            chk($sformatf("halt%0d stall", k), stall_o, 1);
            chk($sformatf("halt%0d valid", k), valid_o, 0);
            chk($sformatf("halt%0d wsel", k), wsel_o, 7);
            tick();
        end
        #2 nRST = 0; #1;
        chk("halt rst halt", halt_o, 0);
        chk("halt rst stall", stall_o, 0);
        chk("halt rst wsel", wsel_o, 0);
        tick(); nRST = 1; idle();

        // Asynchronous reset mid-access drops the request without a clock.
        drive(1, 0, 1, 0, 0, 0, 0, 0, 1, 32'h80, 0, 0, 0); tick();
        idle();
        @(negedge CLK);
        chk("arst ren before", dmemREN, 1);
        #1 nRST = 0; #1;
        chk("arst ren", dmemREN, 0);
        chk("arst addr", dmemaddr, 0);
        chk("arst stall", stall_o, 0);
        tick(); nRST = 1;

        sc_seq(1);
        sc_seq(0);

        nRST = 0; tick(); nRST = 1;
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            int kind;
            kind = $urandom_range(0, 4);
            valid_i = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 6) == 0;
            DRen_i = kind == 2;
            DWen_i = kind >= 3;
            sc_i = kind == 4;
            ll_i = kind == 2 && $urandom_range(0, 1) == 1;
            halt_i = 0;
            RegW_i = sc_i || $urandom_range(0, 1) == 1;
            wsel_i = 5'($urandom);
            aluout_i = kind >= 2 ? 32'h300 + 4 * $urandom_range(0, 2) : $urandom;
            rdat2_i = $urandom;
            npc_i = $urandom;
            dhit = $urandom_range(0, 1);
            dmemload = $urandom;
            ccinv = $urandom_range(0, 4) == 0;
            ccsnoopaddr = 32'h300 + 4 * $urandom_range(0, 2);
            @(negedge CLK);
            model_check(c);
            model_edge();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
